// File: rtl/micro_seq_pkg.sv
// Shared definitions for the table-driven microprogram sequencer:
// FSM encoding, microinstruction field layout and a word-packing helper.
package micro_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_t;

  // Width of the condition-select field: one extra code means "always true".
  function automatic int csel_width(input int n_cond);
    return $clog2(n_cond + 1);
  endfunction

  // Total microinstruction width: {out, csel, inv, nxt_t, nxt_f, halt}.
  function automatic int word_width(input int n_out, input int n_cond, input int addr_w);
    return n_out + csel_width(n_cond) + 1 + 2 * addr_w + 1;
  endfunction

  // Field offsets (LSB positions) inside a microinstruction word.
  function automatic int off_nxt_f();
    return 1;
  endfunction

  function automatic int off_nxt_t(input int addr_w);
    return 1 + addr_w;
  endfunction

  function automatic int off_inv(input int addr_w);
    return 1 + 2 * addr_w;
  endfunction

  function automatic int off_csel(input int addr_w);
    return 2 + 2 * addr_w;
  endfunction

  // Packs one microinstruction into the low bits of a 64-bit word.
  function automatic logic [63:0] pack_uinstr(input int n_out, input int n_cond,
                                              input int addr_w, input int out_val,
                                              input int csel, input logic inv,
                                              input int nxt_t, input int nxt_f,
                                              input logic halt);
    logic [63:0] w;
    logic [63:0] amask;
    logic [63:0] omask;
    amask = (64'd1 << addr_w) - 64'd1;
    omask = (64'd1 << n_out) - 64'd1;
    w = {63'd0, halt};
    w |= (64'(nxt_f) & amask) << off_nxt_f();
    w |= (64'(nxt_t) & amask) << off_nxt_t(addr_w);
    w |= {63'd0, inv} << off_inv(addr_w);
    w |= 64'(csel) << off_csel(addr_w);
    w |= (64'(out_val) & omask) << (off_csel(addr_w) + csel_width(n_cond));
    return w;
  endfunction

endpackage

// File: rtl/micro_seq_rom.sv
// Writable microinstruction table: synchronous write, combinational read,
// whole array cleared by reset.
module micro_seq_rom #(
  parameter int W      = 13,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [W-1:0]      wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [W-1:0]      rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [W-1:0] mem [DEPTH];

  // Table storage: cleared on reset, one word written per strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/micro_seq.sv
// Table-driven microprogram automaton. The transition graph and per-state
// outputs come from micro_seq_rom; this block only walks the table.
//
// Handshake: i_start is sampled in IDLE only (i_abort low) and launches a run
// at address 0; i_abort in RUN or IDLE forces/keeps IDLE on the next edge and
// suppresses o_done; o_done is a single-cycle pulse marking a halt word;
// o_busy is high exactly while in RUN; o_err is sticky until the next
// accepted start and marks a watchdog expiry.
module micro_seq import micro_seq_pkg::*; #(
  parameter  int N_COND    = 3,
  parameter  int N_OUT     = 1,
  parameter  int ADDR_W    = 4,
  parameter  int MAX_STEPS = 255,
  localparam int CSEL_W    = csel_width(N_COND),
  localparam int W         = word_width(N_OUT, N_COND, ADDR_W)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [W-1:0]      i_wdata,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [N_COND-1:0] i_cond,
  output logic [N_OUT-1:0]  o_out,
  output logic [ADDR_W-1:0] o_state,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int OFF_NT   = off_nxt_t(ADDR_W);
  localparam int OFF_NF   = off_nxt_f();
  localparam int OFF_INV  = off_inv(ADDR_W);
  localparam int OFF_CSEL = off_csel(ADDR_W);
  // Step counter only needs to reach MAX_STEPS-1, the value at which the
  // watchdog fires on the following edge.
  localparam int STEP_W   = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'((MAX_STEPS > 0) ? MAX_STEPS - 1 : 0);
  localparam logic [CSEL_W-1:0] CSEL_ALWAYS = CSEL_W'(N_COND);

  fsm_t               state;
  logic [ADDR_W-1:0]  pc;
  logic [STEP_W-1:0]  step;
  logic [N_OUT-1:0]   out_r;
  logic               done_r;
  logic               err_r;

  logic [W-1:0]       word;
  logic [N_OUT-1:0]   w_out;
  logic [CSEL_W-1:0]  w_csel;
  logic               w_inv;
  logic [ADDR_W-1:0]  w_nt;
  logic [ADDR_W-1:0]  w_nf;
  logic               w_halt;
  logic               cond_hit;
  logic               wd_fire;

  // Writes are locked out while a program is running.
  micro_seq_rom #(.W(W), .ADDR_W(ADDR_W)) u_rom (
    .clk   (i_clk),
    .rst   (i_rst),
    .we    (i_we && (state != ST_RUN)),
    .waddr (i_waddr),
    .wdata (i_wdata),
    .raddr (pc),
    .rdata (word)
  );

  assign w_out  = word[W-1 -: N_OUT];
  assign w_csel = word[OFF_CSEL +: CSEL_W];
  assign w_inv  = word[OFF_INV];
  assign w_nt   = word[OFF_NT +: ADDR_W];
  assign w_nf   = word[OFF_NF +: ADDR_W];
  assign w_halt = word[0];

  // Branch condition: selected input xor inv; out-of-range select is "true".
  always_comb begin
    cond_hit = 1'b1;
    if (w_csel < CSEL_ALWAYS) cond_hit = i_cond[w_csel] ^ w_inv;
  end

  assign wd_fire = (MAX_STEPS != 0) && (step == STEP_LAST);

  // Control FSM: IDLE -> RUN -> DONE -> IDLE, with abort and watchdog exits.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= ST_IDLE;
      pc     <= '0;
      step   <= '0;
      out_r  <= '0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (i_start && !i_abort) begin
            state <= ST_RUN;
            pc    <= '0;
            step  <= '0;
            out_r <= '0;
            err_r <= 1'b0;
          end
        end
        ST_RUN: begin
          if (i_abort) begin
            state <= ST_IDLE;
            out_r <= '0;
          end else if (w_halt) begin
            state  <= ST_DONE;
            out_r  <= w_out;
            done_r <= 1'b1;
          end else if (wd_fire) begin
            state <= ST_IDLE;
            out_r <= '0;
            err_r <= 1'b1;
          end else begin
            out_r <= w_out;
            pc    <= cond_hit ? w_nt : w_nf;
            step  <= step + STEP_W'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_out   = out_r;
  assign o_state = pc;
  assign o_busy  = (state == ST_RUN);
  assign o_done  = done_r;
  assign o_err   = err_r;

endmodule

// File: tb/tb_micro_seq.sv
// Directed bench for micro_seq: a table of per-cycle vectors for the main
// graph walk, plus hand-written sequences for reset, watchdog, abort and
// halt/watchdog collision.
module tb_micro_seq;

  localparam int N_COND    = 3;
  localparam int N_OUT     = 1;
  localparam int ADDR_W    = 4;
  localparam int MAX_STEPS = 20;
  localparam int W         = N_OUT + $clog2(N_COND + 1) + 1 + 2 * ADDR_W + 1;

  logic              i_clk;
  logic              i_rst;
  logic              i_we;
  logic [ADDR_W-1:0] i_waddr;
  logic [W-1:0]      i_wdata;
  logic              i_start;
  logic              i_abort;
  logic [N_COND-1:0] i_cond;
  logic [N_OUT-1:0]  o_out;
  logic [ADDR_W-1:0] o_state;
  logic              o_busy;
  logic              o_done;
  logic              o_err;

  micro_seq #(
    .N_COND(N_COND), .N_OUT(N_OUT), .ADDR_W(ADDR_W), .MAX_STEPS(MAX_STEPS)
  ) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (i_we),
    .i_waddr (i_waddr),
    .i_wdata (i_wdata),
    .i_start (i_start),
    .i_abort (i_abort),
    .i_cond  (i_cond),
    .o_out   (o_out),
    .o_state (o_state),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_err   (o_err)
  );

  // Clock
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int checks;
  int errors;

  typedef struct {
    logic              start;
    logic [N_COND-1:0] cond;
    logic [ADDR_W-1:0] st;
    logic              out;
    logic              busy;
    logic              done;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Microinstruction built field by field: {out, csel, inv, nxt_t, nxt_f, halt}.
  function automatic logic [W-1:0] mk(input int out_v, input int csel, input logic inv,
                                      input int nt, input int nf, input logic halt);
    return {1'(out_v), 2'(csel), inv, 4'(nt), 4'(nf), halt};
  endfunction

  task automatic write_word(input int a, input logic [W-1:0] d);
    i_we    = 1'b1;
    i_waddr = ADDR_W'(a);
    i_wdata = d;
    tick();
    i_we    = 1'b0;
  endtask

  // 10-state graph: Y0..Y8 plus Yk (9) as the halt word; 5..7 are halt fillers.
  task automatic load_graph();
    write_word(0, mk(0, 1, 1'b0, 1, 0, 1'b0));  // x2 ? 1 : 0
    write_word(1, mk(1, 3, 1'b0, 2, 2, 1'b0));  // -> 2
    write_word(2, mk(1, 3, 1'b0, 3, 3, 1'b0));  // -> 3
    write_word(3, mk(1, 0, 1'b1, 4, 5, 1'b0));  // !x1 ? 4 : 5
    write_word(4, mk(1, 2, 1'b1, 2, 8, 1'b0));  // !x3 ? 2 : 8
    write_word(5, mk(0, 3, 1'b0, 5, 5, 1'b1));
    write_word(6, mk(0, 3, 1'b0, 6, 6, 1'b1));
    write_word(7, mk(0, 3, 1'b0, 7, 7, 1'b1));
    write_word(8, mk(1, 3, 1'b0, 9, 9, 1'b0));  // -> 9
    write_word(9, mk(0, 3, 1'b0, 9, 9, 1'b1));  // halt
  endtask

  int busy_cnt;
  int done_cnt;
  int bad_cnt;

  initial begin
    checks  = 0;
    errors  = 0;
    i_rst   = 1'b1;
    i_we    = 1'b0;
    i_waddr = '0;
    i_wdata = '0;
    i_start = 1'b0;
    i_abort = 1'b0;
    i_cond  = '0;

    // start, cond, expected state, out, busy, done (after the edge)
    vecs[0]  = '{1'b1, 3'b010, 4'd0, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 3'b010, 4'd1, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 3'b010, 4'd2, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 3'b010, 4'd3, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 3'b010, 4'd4, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 3'b010, 4'd2, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 3'b010, 4'd3, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 3'b010, 4'd4, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 3'b110, 4'd8, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 3'b110, 4'd9, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 3'b000, 4'd9, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 3'b000, 4'd9, 1'b0, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_state", 32'(o_state), 0);
    check("rst_out",   32'(o_out),   0);
    check("rst_busy",  32'(o_busy),  0);
    check("rst_done",  32'(o_done),  0);
    check("rst_err",   32'(o_err),   0);
    i_rst = 1'b0;
    tick();

    // Main graph walk, table-driven
    load_graph();
    for (int i = 0; i < 12; i++) begin
      i_start = vecs[i].start;
      i_cond  = vecs[i].cond;
      tick();
      i_start = 1'b0;
      check($sformatf("vec%0d_state", i), 32'(o_state), 32'(vecs[i].st));
      check($sformatf("vec%0d_out", i),   32'(o_out),   32'(vecs[i].out));
      check($sformatf("vec%0d_busy", i),  32'(o_busy),  32'(vecs[i].busy));
      check($sformatf("vec%0d_done", i),  32'(o_done),  32'(vecs[i].done));
    end
    check("graph_err", 32'(o_err), 0);

    // Reset in the middle of a run
    i_cond  = 3'b010;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    tick();
    check("midrun_busy", 32'(o_busy), 1);
    check("midrun_out", 32'(o_out), 1);
    #2 i_rst = 1'b1;
    #1;
    check("async_rst_state", 32'(o_state), 0);
    check("async_rst_out",   32'(o_out),   0);
    check("async_rst_busy",  32'(o_busy),  0);
    check("async_rst_done",  32'(o_done),  0);
    tick();
    i_rst = 1'b0;
    tick();

    // Cleared table self-loops at 0 until the watchdog fires
    i_cond  = 3'b111;
    i_start = 1'b1;
    tick();
    i_start  = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    bad_cnt  = 0;
    for (int i = 0; i < 30; i++) begin
      if (o_busy) busy_cnt++;
      if (o_done) done_cnt++;
      if (o_state != 0 || o_out != 0) bad_cnt++;
      if (o_busy && o_err) bad_cnt++;
      tick();
    end
    check("wd_busy_cycles", 32'(busy_cnt), 20);
    check("wd_no_done", 32'(done_cnt), 0);
    check("wd_loop_at_0", 32'(bad_cnt), 0);
    check("wd_err", 32'(o_err), 1);

    // Next start clears err; abort at step 5 with start high; write in RUN ignored
    load_graph();
    check("err_sticky_idle", 32'(o_err), 1);
    i_cond  = 3'b010;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("start_clears_err", 32'(o_err), 0);
    tick();
    tick();
    i_we    = 1'b1;
    i_waddr = 4'd1;
    i_wdata = mk(1, 3, 1'b0, 1, 1, 1'b1);
    tick();
    i_we = 1'b0;
    tick();
    tick();
    check("pre_abort_state", 32'(o_state), 2);
    check("pre_abort_out", 32'(o_out), 1);
    i_abort = 1'b1;
    i_start = 1'b1;
    tick();
    check("abort_busy", 32'(o_busy), 0);
    check("abort_out",  32'(o_out),  0);
    check("abort_done", 32'(o_done), 0);
    i_abort = 1'b0;
    i_start = 1'b0;
    tick();
    check("abort_no_done_later", 32'(o_done), 0);
    check("abort_stays_idle", 32'(o_busy), 0);

    // Readback: word 1 must still branch to 2, not halt
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    tick();
    check("readback_state", 32'(o_state), 2);
    check("readback_busy", 32'(o_busy), 1);
    check("readback_done", 32'(o_done), 0);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    check("readback_abort", 32'(o_busy), 0);

    // Start and abort together in IDLE: abort wins
    i_start = 1'b1;
    i_abort = 1'b1;
    tick();
    check("start_abort_idle_busy", 32'(o_busy), 0);
    check("start_abort_idle_done", 32'(o_done), 0);
    i_start = 1'b0;
    i_abort = 1'b0;
    tick();
    check("start_abort_idle_after", 32'(o_busy), 0);

    // Halt lands on the same edge as the watchdog: halt wins
    write_word(0, mk(0, 0, 1'b0, 1, 0, 1'b0));  // x1 ? 1 : 0
    write_word(1, mk(1, 3, 1'b0, 1, 1, 1'b1));  // halt, out=1
    i_cond  = 3'b000;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (18) tick();
    check("hw_wait_busy", 32'(o_busy), 1);
    check("hw_wait_state", 32'(o_state), 0);
    i_cond = 3'b001;
    tick();
    i_cond = 3'b000;
    check("hw_at_halt_state", 32'(o_state), 1);
    check("hw_at_halt_busy", 32'(o_busy), 1);
    tick();
    check("hw_done", 32'(o_done), 1);
    check("hw_err",  32'(o_err),  0);
    check("hw_busy", 32'(o_busy), 0);
    check("hw_out",  32'(o_out),  1);
    // Start during DONE is ignored
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("done_start_ignored", 32'(o_busy), 0);
    check("done_pulse_one_cycle", 32'(o_done), 0);
    check("out_held_after_halt", 32'(o_out), 1);
    tick();
    check("still_idle", 32'(o_busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
